// File: rtl/img_stream_pkg.sv
// Shared types and defaults for the 8-bit grayscale frame stream.
// Downstream window/filter stages reuse the pixel width and the default
// frame geometry from here.
package img_stream_pkg;

    localparam int PIX_W     = 8;
    localparam int DEF_IMG_W = 640;
    localparam int DEF_IMG_H = 480;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VFRONT = 3'd1,
        ST_LINE   = 3'd2,
        ST_HBLANK = 3'd3,
        ST_VBACK  = 3'd4,
        ST_FBLANK = 3'd5
    } state_t;

    // Largest of the four blanking lengths; sizes the shared cycle counter.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/frame_stream_gen.sv
// Frame stream source: pulls pixels over ready/valid and emits the
// vsync/hsync/valid/pixel stream with all porch and gap timing.
// Every output is registered; a source fire in cycle t appears at t+1.
module frame_stream_gen
    import img_stream_pkg::*;
#(
    parameter int IMG_W   = DEF_IMG_W,
    parameter int IMG_H   = DEF_IMG_H,
    parameter int H_BLANK = 16,
    parameter int V_FRONT = 8,
    parameter int V_BACK  = 8,
    parameter int F_BLANK = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             src_valid,
    input  logic [PIX_W-1:0] src_data,
    output logic             src_ready,
    output logic             post_frame_vsync,
    output logic             post_frame_hsync,
    output logic             post_frame_valid,
    output logic [PIX_W-1:0] post_img_y,
    output logic             frame_done,
    output logic             busy
);

    localparam int CNT_MAX = max4(H_BLANK, V_FRONT, V_BACK, F_BLANK);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int X_W     = $clog2(IMG_W);
    localparam int Y_W     = $clog2(IMG_H);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0] VF_LAST  = CNT_W'(V_FRONT - 1);
    localparam logic [CNT_W-1:0] VB_LAST  = CNT_W'(V_BACK - 1);
    localparam logic [CNT_W-1:0] FB_LAST  = CNT_W'(F_BLANK - 1);
    localparam logic [X_W-1:0]   X_ZERO   = {X_W{1'b0}};
    localparam logic [X_W-1:0]   X_ONE    = X_W'(1);
    localparam logic [X_W-1:0]   X_LAST   = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0]   Y_ZERO   = {Y_W{1'b0}};
    localparam logic [Y_W-1:0]   Y_ONE    = Y_W'(1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(IMG_H - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;

    logic               vsync_q, vsync_d;
    logic               hsync_q, hsync_d;
    logic               valid_q, valid_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic               done_q, done_d;

    logic               fire_s;

    // The source is only ever offered a slot while a line is active.
    assign src_ready = (state_q == ST_LINE);
    assign fire_s    = src_ready && src_valid;

    // Next-state logic for the timing FSM plus the values the output stage captures.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        vsync_d = 1'b0;
        hsync_d = 1'b0;
        valid_d = fire_s;
        done_d  = 1'b0;
        if (fire_s) begin
            pix_d = src_data;
        end else begin
            pix_d = pix_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_VFRONT;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_VFRONT: begin
                vsync_d = 1'b1;
                if (cnt_q == VF_LAST) begin
                    state_d = ST_LINE;
                    cnt_d   = CNT_ZERO;
                    x_d     = X_ZERO;
                    y_d     = Y_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_LINE: begin
                vsync_d = 1'b1;
                hsync_d = 1'b1;
                if (fire_s) begin
                    if (x_q == X_LAST) begin
                        x_d   = X_ZERO;
                        cnt_d = CNT_ZERO;
                        if (y_q == Y_LAST) begin
                            state_d = ST_VBACK;
                        end else begin
                            state_d = ST_HBLANK;
                        end
                    end else begin
                        x_d = x_q + X_ONE;
                    end
                end else begin
                    state_d = ST_LINE;
                end
            end
            ST_HBLANK: begin
                vsync_d = 1'b1;
                if (cnt_q == HB_LAST) begin
                    state_d = ST_LINE;
                    cnt_d   = CNT_ZERO;
                    x_d     = X_ZERO;
                    y_d     = y_q + Y_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_VBACK: begin
                vsync_d = 1'b1;
                if (cnt_q == VB_LAST) begin
                    state_d = ST_FBLANK;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_FBLANK: begin
                // Captured on the first FBLANK cycle so the pulse lands in the
                // first cycle the registered vsync is low.
                done_d = (cnt_q == CNT_ZERO);
                if (cnt_q == FB_LAST) begin
                    cnt_d = CNT_ZERO;
                    if (enable) begin
                        state_d = ST_VFRONT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                x_d     = X_ZERO;
                y_d     = Y_ZERO;
            end
        endcase
    end

    // FSM state and position counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            x_q     <= X_ZERO;
            y_q     <= Y_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // Registered output stage; one cycle behind the FSM state and source fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q <= 1'b0;
            hsync_q <= 1'b0;
            valid_q <= 1'b0;
            pix_q   <= {PIX_W{1'b0}};
            done_q  <= 1'b0;
        end else begin
            vsync_q <= vsync_d;
            hsync_q <= hsync_d;
            valid_q <= valid_d;
            pix_q   <= pix_d;
            done_q  <= done_d;
        end
    end

    assign post_frame_vsync = vsync_q;
    assign post_frame_hsync = hsync_q;
    assign post_frame_valid = valid_q;
    assign post_img_y       = pix_q;
    assign frame_done       = done_q;
    assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_frame_stream_gen.sv
// Bench for frame_stream_gen on a small 4x3 frame. A count-down timeline
// model predicts every output each cycle; frame-level statistics gathered
// from the DUT outputs are also pinned against hand-computed constants.
module tb_frame_stream_gen;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int HB = 2;
    localparam int VF = 1;
    localparam int VB = 1;
    localparam int FB = 3;

    localparam int P_IDLE  = 0;
    localparam int P_FRONT = 1;
    localparam int P_LINE  = 2;
    localparam int P_HGAP  = 3;
    localparam int P_BACK  = 4;
    localparam int P_FGAP  = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       src_valid;
    logic [7:0] src_data;
    logic       src_ready;
    logic       post_frame_vsync;
    logic       post_frame_hsync;
    logic       post_frame_valid;
    logic [7:0] post_img_y;
    logic       frame_done;
    logic       busy;

    always #5 clk = ~clk;

    frame_stream_gen #(
        .IMG_W(W), .IMG_H(H), .H_BLANK(HB),
        .V_FRONT(VF), .V_BACK(VB), .F_BLANK(FB)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .post_frame_vsync(post_frame_vsync), .post_frame_hsync(post_frame_hsync),
        .post_frame_valid(post_frame_valid), .post_img_y(post_img_y),
        .frame_done(frame_done), .busy(busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model state ----------------
    bit         m_known = 1'b0;
    int         m_phase, m_left, m_px_left, m_lines_left;
    logic       e_vs, e_hs, e_val, e_done, fire_m;
    logic [7:0] e_pix;

    // ---------------- statistics from DUT outputs ----------------
    logic [7:0] pix_log[$];
    int frame_pix, last_frame_pix, vs_run, last_vs_len, vs_low_run, last_vs_gap;
    int vs_rises, frames_total, frames_good, done_cnt;
    int hs_novalid, last_hs_novalid, stall_pix;
    int hs_low_run, hgap_min, hgap_max, win_cnt, win_min, win_max, windows;
    bit hs_fell_in_frame;
    logic vs_prev = 1'b0, hs_prev = 1'b0;

    task automatic clear_stats();
        pix_log.delete();
        frame_pix = 0; last_frame_pix = -1; vs_run = 0; last_vs_len = -1;
        vs_low_run = 0; last_vs_gap = -1; vs_rises = 0; frames_total = 0;
        frames_good = 0; done_cnt = 0; hs_novalid = 0; last_hs_novalid = -1;
        stall_pix = -1; hs_low_run = 0; hgap_min = 999; hgap_max = -1;
        win_cnt = 0; win_min = 999; win_max = -1; windows = 0;
        hs_fell_in_frame = 1'b0;
    endtask

    // Per-cycle compare against the model, statistics gathering, then model advance.
    always @(negedge clk) begin
        if (m_known) begin
            chk("vsync", post_frame_vsync, e_vs);
            chk("hsync", post_frame_hsync, e_hs);
            chk("valid", post_frame_valid, e_val);
            chk("pixel", post_img_y, e_pix);
            chk("frame_done", frame_done, e_done);
            chk("src_ready", src_ready, m_phase == P_LINE);
            chk("busy", busy, m_phase != P_IDLE);
        end

        if (post_frame_vsync === 1'b1 && vs_prev !== 1'b1) begin
            last_vs_gap = vs_low_run; vs_rises++; frame_pix = 0; vs_run = 0; hs_novalid = 0;
        end
        if (post_frame_vsync !== 1'b1 && vs_prev === 1'b1) begin
            last_vs_len = vs_run; last_frame_pix = frame_pix; last_hs_novalid = hs_novalid;
            frames_total++;
            if (frame_pix == W * H) frames_good++;
            vs_low_run = 0; hs_fell_in_frame = 1'b0;
        end
        if (post_frame_vsync === 1'b1) vs_run++; else vs_low_run++;

        if (post_frame_hsync === 1'b1 && hs_prev !== 1'b1) begin
            win_cnt = 0; windows++;
            if (hs_fell_in_frame) begin
                if (hs_low_run < hgap_min) hgap_min = hs_low_run;
                if (hs_low_run > hgap_max) hgap_max = hs_low_run;
            end
        end
        if (post_frame_hsync !== 1'b1 && hs_prev === 1'b1) begin
            if (win_cnt < win_min) win_min = win_cnt;
            if (win_cnt > win_max) win_max = win_cnt;
            hs_fell_in_frame = 1'b1; hs_low_run = 0;
        end
        if (post_frame_vsync === 1'b1 && post_frame_hsync !== 1'b1) hs_low_run++;

        if (post_frame_valid === 1'b1) begin
            pix_log.push_back(post_img_y); frame_pix++; win_cnt++;
        end
        if (post_frame_hsync === 1'b1 && post_frame_valid !== 1'b1) begin
            hs_novalid++; stall_pix = post_img_y;
        end
        if (frame_done === 1'b1) done_cnt++;
        vs_prev = post_frame_vsync;
        hs_prev = post_frame_hsync;

        // Inputs seen here are exactly what the next rising edge samples.
        if (rst) begin
            m_known = 1'b1; m_phase = P_IDLE; m_left = 0; m_px_left = 0; m_lines_left = 0;
            e_vs = 1'b0; e_hs = 1'b0; e_val = 1'b0; e_done = 1'b0; e_pix = 8'd0;
        end else if (m_known) begin
            fire_m = (m_phase == P_LINE) && src_valid;
            e_vs   = (m_phase == P_FRONT) || (m_phase == P_LINE) || (m_phase == P_HGAP) || (m_phase == P_BACK);
            e_hs   = (m_phase == P_LINE);
            e_val  = fire_m;
            e_done = (m_phase == P_FGAP) && (m_left == FB);
            if (fire_m) e_pix = src_data;
            case (m_phase)
                P_IDLE: if (enable) begin m_phase = P_FRONT; m_left = VF; end
                P_FRONT: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = P_LINE; m_px_left = W; m_lines_left = H; end
                end
                P_LINE: if (fire_m) begin
                    m_px_left--;
                    if (m_px_left == 0) begin
                        m_lines_left--;
                        if (m_lines_left == 0) begin m_phase = P_BACK; m_left = VB; end
                        else begin m_phase = P_HGAP; m_left = HB; end
                    end
                end
                P_HGAP: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = P_LINE; m_px_left = W; end
                end
                P_BACK: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = P_FGAP; m_left = FB; end
                end
                P_FGAP: begin
                    m_left--;
                    if (m_left == 0) begin
                        if (enable) begin m_phase = P_FRONT; m_left = VF; end
                        else m_phase = P_IDLE;
                    end
                end
                default: m_phase = P_IDLE;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    int data_ctr = 0;
    int stall_at = -1;
    int stall_len = 0;
    int stall_left = 0;
    bit stall_pending = 1'b0;

    // One clock: note whether this edge fires, then update source data/valid.
    task automatic step();
        logic f;
        @(negedge clk);
        f = src_ready && src_valid;
        @(posedge clk);
        #1;
        if (f) data_ctr++;
        src_data = data_ctr[7:0];
        if (stall_pending && data_ctr == stall_at) begin
            src_valid = 1'b0; stall_left = stall_len; stall_pending = 1'b0;
        end else if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) src_valid = 1'b1;
        end
    endtask

    task automatic run_until_idle(input int budget, input string tag);
        int n;
        n = 0;
        do begin step(); n++; end while (busy !== 1'b0 && n < budget);
        if (busy !== 1'b0) chk({tag, "_idle_timeout"}, busy, 1'b0);
    endtask

    task automatic check_log(input string tag, input int n);
        chk({tag, "_log_size"}, pix_log.size(), n);
        for (int i = 0; i < n && i < pix_log.size(); i++)
            chk($sformatf("%s_pix%0d", tag, i), pix_log[i], i);
    endtask

    task automatic start_frame();
        data_ctr = 0; src_data = 8'd0; src_valid = 1'b1; enable = 1'b1;
        step();
        enable = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; enable = 1'b0; src_valid = 1'b0; src_data = 8'd0;
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_vsync", post_frame_vsync, 1'b0);
        chk("rst_hsync", post_frame_hsync, 1'b0);
        chk("rst_valid", post_frame_valid, 1'b0);
        chk("rst_pixel", post_img_y, 8'd0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", src_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Plain frame; enable dropped right after start, so it also ends in IDLE.
        clear_stats();
        start_frame();
        run_until_idle(100, "s1");
        check_log("s1", W * H);
        chk("s1_frame_pix", last_frame_pix, 12);
        chk("s1_vs_len", last_vs_len, 18);
        chk("s1_done_cnt", done_cnt, 1);
        chk("s1_hgap_min", hgap_min, 2);
        chk("s1_hgap_max", hgap_max, 2);
        chk("s1_windows", windows, 3);
        chk("s1_win_min", win_min, 4);
        chk("s1_win_max", win_max, 4);
        chk("s1_hs_novalid", last_hs_novalid, 0);
        repeat (10) step();
        chk("s1_no_restart", vs_rises, 1);
        chk("s1_busy_after", busy, 1'b0);

        // Three-cycle source stall after the second pixel of line 1.
        clear_stats();
        stall_at = 6; stall_len = 3; stall_pending = 1'b1;
        start_frame();
        run_until_idle(100, "s2");
        check_log("s2", W * H);
        chk("s2_vs_len", last_vs_len, 21);
        chk("s2_hs_novalid", last_hs_novalid, 3);
        chk("s2_stall_pix", stall_pix, 5);
        chk("s2_done_cnt", done_cnt, 1);

        // Enable held across two frames.
        clear_stats();
        data_ctr = 0; src_data = 8'd0; src_valid = 1'b1; enable = 1'b1;
        n = 0;
        do begin step(); n++; end while (done_cnt < 2 && n < 200);
        chk("s3_done_reached", done_cnt, 2);
        enable = 1'b0;
        run_until_idle(100, "s3");
        chk("s3_frames", frames_total, 2);
        chk("s3_frames_good", frames_good, 2);
        chk("s3_vs_gap", last_vs_gap, 3);
        chk("s3_vs_rises", vs_rises, 2);
        check_log("s3", 2 * W * H);

        // Reset in line 2 with enable also high; reset must win.
        clear_stats();
        start_frame();
        n = 0;
        while (data_ctr < 9 && n < 100) begin step(); n++; end
        chk("s5_reached_line2", data_ctr, 9);
        rst = 1'b1; enable = 1'b1;
        step();
        rst = 1'b0; enable = 1'b0;
        @(negedge clk);
        chk("s5_vsync", post_frame_vsync, 1'b0);
        chk("s5_hsync", post_frame_hsync, 1'b0);
        chk("s5_valid", post_frame_valid, 1'b0);
        chk("s5_pixel", post_img_y, 8'd0);
        chk("s5_done", frame_done, 1'b0);
        chk("s5_busy", busy, 1'b0);
        repeat (6) step();
        chk("s5_no_done", done_cnt, 0);
        chk("s5_still_idle", busy, 1'b0);
        clear_stats();
        start_frame();
        run_until_idle(100, "s5");
        check_log("s5", W * H);
        chk("s5_frame_pix", last_frame_pix, 12);
        chk("s5_vs_len", last_vs_len, 18);
        chk("s5_done_cnt", done_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop if the run ever wedges.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/frame_stream_gen.md
# frame_stream_gen

Source-side generator for the team's 8-bit grayscale frame stream: accepts pixels over a ready/valid handshake from a frame buffer or pattern source and emits the vsync/hsync/valid/pixel stream consumed by the 3x3 window and filter stages. It owns all frame and line timing (front porch, inter-line gap, back porch, inter-frame gap). Source stalls appear as valid gaps inside an active line.

## Interface
Parameters:
- IMG_W, 640, active pixels per line (≥2)
- IMG_H, 480, active lines per frame (≥2)
- H_BLANK, 16, cycles of hsync low between lines (≥1)
- V_FRONT, 8, cycles of vsync high before the first line (≥1)
- V_BACK, 8, cycles of vsync high after the last line (≥1)
- F_BLANK, 32, cycles of vsync low between frames (≥1)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- enable  in  1  start/continue frame generation
- src_valid  in  1  source pixel available
- src_data  in  8  source pixel
- src_ready  out  1  pixel accepted when src_valid && src_ready
- post_frame_vsync  out  1  high for the whole frame, porches included
- post_frame_hsync  out  1  high during each active line
- post_frame_valid  out  1  pixel beat on post_img_y
- post_img_y  out  8  pixel value
- frame_done  out  1  one-cycle pulse at end of frame
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, VFRONT, LINE, HBLANK, VBACK, FBLANK. A single cycle counter `cnt` serves the timed states; x/y counters track pixel and line; widths are $clog2 of the largest range.
- IDLE: if enable → VFRONT, cnt=0.
- VFRONT: after V_FRONT cycles → LINE, x=0, y=0.
- LINE: src_ready=1 (combinational from state). Each fire increments x. The fire with x=IMG_W-1 moves to HBLANK if y<IMG_H-1, else to VBACK. No fire → stay (stall).
- HBLANK: after H_BLANK cycles → LINE, x=0, y+1.
- VBACK: after V_BACK cycles → FBLANK, assert frame_done.
- FBLANK: after F_BLANK cycles → VFRONT if enable, else IDLE.
- enable is sampled only in IDLE and at FBLANK exit. Deassertion mid-frame completes the current frame.
- src_ready=0 in all states other than LINE. src_data outside a fire is ignored.
- Outputs are registered from state/fire:
  - vsync ← state∈{VFRONT,LINE,HBLANK,VBACK}
  - hsync ← state==LINE
  - valid ← fire
  - post_img_y ← src_data on fire, otherwise held
- Every line carries exactly IMG_W valid beats; every frame carries exactly IMG_H lines.

## Timing
- Latency: a fire in cycle t produces valid/post_img_y in cycle t+1.
- hsync rises in the same cycle as the earliest possible first valid. It falls one cycle after the last valid of the line, so the last pixel is always inside hsync.
- vsync-high cycles per frame = V_FRONT + (IMG_H-1)·H_BLANK + V_BACK + (LINE cycles, where LINE cycles = IMG_W·IMG_H plus stall cycles).
- frame_done is high in the first cycle vsync is low.
- A stall inside a line holds hsync=1 and valid=0; post_img_y keeps the last pixel.
- Reset values: all outputs 0, post_img_y=0, state IDLE, counters 0.
- Reset mid-frame: state, counters and outputs return to reset values on the next edge. No frame_done is generated.
- enable and rst together: rst wins.

## Structure
- img_stream_pkg holds:
  - the state enum type
  - PIX_W=8
  - shared defaults IMG_W/IMG_H, for reuse by downstream window/filter blocks
- No sub-module: the FSM, counters and output register stage fit in one module.

## Test plan
Small-frame parameters for all scenarios: IMG_W=4, IMG_H=3, H_BLANK=2, V_FRONT=1, V_BACK=1, F_BLANK=3.
- Reset then enable=1, src_valid always 1, src_data=0..11 → 12 valid beats carrying 0..11 in order, 4 per hsync window; hsync low exactly 2 cycles between lines; vsync high 18 cycles; frame_done pulses once, coincident with the vsync fall.
- Same setup, src_valid dropped for 3 cycles after the 2nd pixel of line 1 → hsync stays high through the gap; valid low for 3 cycles; post_img_y holds 5; vsync high 21 cycles.
- enable held 1 → consecutive frames separated by exactly 3 cycles of vsync low; pixel count 12 per frame.
- enable dropped mid-frame → frame completes with 12 pixels, frame_done pulses, FSM returns to IDLE, busy=0, no further vsync.
- rst asserted for one cycle during line 2 → all outputs 0 on the next cycle, busy=0. A subsequent enable starts a full fresh frame of 12 pixels.
- src_valid=1 during blanking states → src_ready=0 and no valid beats generated.
